// File: rtl/prbs_lock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : prbs_lock_ctrl
//  Description : PRBS checker lock controller: seed sync, hunt, lock and
//                loss-of-lock supervision with bit-error/resync statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module prbs_lock_ctrl #(
    parameter int LOCK_CNT     = 16,
    parameter int ERR_THRESH   = 4,
    parameter int WINDOW       = 256,
    parameter int SYNC_HOLD    = 4,
    parameter int SEED_WAIT    = 8,
    parameter int HUNT_TIMEOUT = 1024
) (
    input  logic        C,
    input  logic        R,
    input  logic        en,
    input  logic        rxen,
    input  logic        CE,
    input  logic [15:0] rx_data,
    input  logic [15:0] exp_data,
    input  logic        clr_cnt,
    output logic        sync,
    output logic        locked,
    output logic        err_word,
    output logic [31:0] bit_err_cnt,
    output logic [15:0] resync_cnt,
    output logic [2:0]  state_o
);

    localparam int TMR_MAX = (SYNC_HOLD > SEED_WAIT) ? SYNC_HOLD : SEED_WAIT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int GOOD_W  = $clog2(LOCK_CNT + 1);
    localparam int HUNT_W  = $clog2(HUNT_TIMEOUT + 1);
    localparam int WIN_W   = $clog2(WINDOW + 1);
    localparam int ERRC_W  = $clog2(ERR_THRESH + 1);

    localparam logic [TMR_W-1:0]  SYNC_LAST = TMR_W'(SYNC_HOLD - 1);
    localparam logic [TMR_W-1:0]  WAIT_LAST = TMR_W'(SEED_WAIT - 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
    localparam logic [HUNT_W-1:0] HUNT_LAST = HUNT_W'(HUNT_TIMEOUT - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [ERRC_W-1:0] ERR_LAST  = ERRC_W'(ERR_THRESH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_HUNT   = 3'd3,
        ST_LOCKED = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [GOOD_W-1:0]  good_q, good_d;
    logic [HUNT_W-1:0]  hunt_q, hunt_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [ERRC_W-1:0]  errc_q, errc_d;
    logic               sync_q, sync_d;
    logic               locked_q, locked_d;
    logic               err_word_q, err_word_d;
    logic [31:0]        bit_err_cnt_q, bit_err_cnt_d;
    logic [15:0]        resync_cnt_q, resync_cnt_d;

    logic               mismatch;
    logic [15:0]        diff;
    logic [4:0]         pop;
    logic [32:0]        bec_sum;
    logic               rsc_inc;

    assign diff     = rx_data ^ exp_data;
    assign mismatch = |diff;

    always_comb begin
        pop = '0;
        for (int i = 0; i < 16; i++) begin
            pop = pop + {4'd0, diff[i]};
        end
    end

    assign bec_sum = {1'b0, bit_err_cnt_q} + {28'd0, pop};

    always_comb begin
        state_d = state_q;
        tmr_d   = '0;
        good_d  = '0;
        hunt_d  = '0;
        win_d   = '0;
        errc_d  = '0;
        rsc_inc = 1'b0;

        case (state_q)
            ST_IDLE: state_d = ST_SYNC;
            ST_SYNC: begin
                if (tmr_q == SYNC_LAST) state_d = ST_WAIT;
                else                    tmr_d   = tmr_q + TMR_W'(1);
            end
            ST_WAIT: begin
                if (tmr_q == WAIT_LAST) state_d = ST_HUNT;
                else                    tmr_d   = tmr_q + TMR_W'(1);
            end
            ST_HUNT: begin
                good_d = good_q;
                hunt_d = hunt_q;
                if (CE) begin
                    good_d = mismatch ? '0 : good_q + GOOD_W'(1);
                    hunt_d = hunt_q + HUNT_W'(1);
                    // Reaching lock on the last allowed word beats the timeout.
                    if (!mismatch && good_q == GOOD_LAST) begin
                        state_d = ST_LOCKED;
                        good_d  = '0;
                        hunt_d  = '0;
                    end else if (hunt_q == HUNT_LAST) begin
                        state_d = ST_SYNC;
                        good_d  = '0;
                        hunt_d  = '0;
                    end
                end
            end
            ST_LOCKED: begin
                win_d  = win_q;
                errc_d = errc_q;
                if (CE) begin
                    win_d = (win_q == WIN_LAST) ? '0 : win_q + WIN_W'(1);
                    // An errored word on the wrap cycle still belongs to the closing window.
                    if (mismatch && errc_q == ERR_LAST) begin
                        state_d = ST_SYNC;
                        rsc_inc = 1'b1;
                        win_d   = '0;
                        errc_d  = '0;
                    end else if (win_q == WIN_LAST) begin
                        errc_d = '0;
                    end else if (mismatch) begin
                        errc_d = errc_q + ERRC_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!en || !rxen) begin
            state_d = ST_IDLE;
            tmr_d   = '0;
            good_d  = '0;
            hunt_d  = '0;
            win_d   = '0;
            errc_d  = '0;
            rsc_inc = 1'b0;
        end
    end

    always_comb begin
        sync_d     = (state_d == ST_SYNC);
        locked_d   = (state_d == ST_LOCKED);
        err_word_d = CE && mismatch && (state_q == ST_HUNT || state_q == ST_LOCKED);

        bit_err_cnt_d = bit_err_cnt_q;
        if (state_q == ST_LOCKED && CE) begin
            bit_err_cnt_d = bec_sum[32] ? 32'hFFFF_FFFF : bec_sum[31:0];
        end
        if (clr_cnt) bit_err_cnt_d = '0;

        resync_cnt_d = resync_cnt_q;
        if (rsc_inc && resync_cnt_q != 16'hFFFF) begin
            resync_cnt_d = resync_cnt_q + 16'd1;
        end
        if (clr_cnt) resync_cnt_d = '0;
    end

    always_ff @(posedge C) begin
        if (!R) begin
            state_q       <= ST_IDLE;
            tmr_q         <= '0;
            good_q        <= '0;
            hunt_q        <= '0;
            win_q         <= '0;
            errc_q        <= '0;
            sync_q        <= 1'b0;
            locked_q      <= 1'b0;
            err_word_q    <= 1'b0;
            bit_err_cnt_q <= '0;
            resync_cnt_q  <= '0;
        end else begin
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            good_q        <= good_d;
            hunt_q        <= hunt_d;
            win_q         <= win_d;
            errc_q        <= errc_d;
            sync_q        <= sync_d;
            locked_q      <= locked_d;
            err_word_q    <= err_word_d;
            bit_err_cnt_q <= bit_err_cnt_d;
            resync_cnt_q  <= resync_cnt_d;
        end
    end

    assign sync        = sync_q;
    assign locked      = locked_q;
    assign err_word    = err_word_q;
    assign bit_err_cnt = bit_err_cnt_q;
    assign resync_cnt  = resync_cnt_q;
    assign state_o     = state_q;

endmodule
`default_nettype wire
